mem_bus_sequencer: RTL and testbench
====================================

# mem_bus_sequencer

Sequences the MIPS CPU's separate instruction-fetch and data-access ports onto the single Avalon memory-mapped master bus. It serialises each CPU cycle's requests: the data access goes first, then the instruction fetch. It holds the CPU in stall until both are complete and returns registered read data. It sits between `mips_cpu` and the top-level Avalon master ports inside `cpu_interface`.

## Interface
- `WAIT_LIMIT`, 255: consecutive `waitrequest`-high cycles tolerated before a bus error; used only when `MEM_BUS_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_req`  in  1  CPU requests an instruction fetch.
- `instr_address`  in  32  fetch address.
- `instr_readdata`  out  32  registered fetched instruction.
- `data_read`  in  1  CPU load request.
- `data_write`  in  1  CPU store request.
- `data_address`  in  32  load/store address.
- `data_writedata`  in  32  store data.
- `data_byteenable`  in  4  store/load byte lanes.
- `data_readdata`  out  32  registered load data.
- `stall`  out  1  CPU must not advance; request inputs are held constant while high.
- `address`  out  32  Avalon address.
- `read`  out  1  Avalon read strobe.
- `write`  out  1  Avalon write strobe.
- `waitrequest`  in  1  Avalon slave wait.
- `writedata`  out  32  Avalon write data.
- `byteenable`  out  4  Avalon byte lanes.
- `readdata`  in  32  Avalon read data, valid in the completing cycle.
- `bus_error`  out  1  sticky timeout flag.

## Operation
- States: IDLE, DATA, FETCH, RESP, ERROR.
- IDLE:
  - If `data_write|data_read`, go to DATA; otherwise if `instr_req`, go to FETCH.
  - Latch all request inputs on this edge.
- DATA:
  - Drive the latched data address, byteenable and writedata.
  - If `data_write` is set, assert `write`; otherwise assert `read`. Write wins if both are set, and the read is dropped.
- Transfer completion: a rising edge with strobe high and `waitrequest` low.
  - On a DATA read completion, `data_readdata <= readdata`.
  - After DATA completes, go to FETCH if `instr_req` was latched, else RESP.
- FETCH:
  - Assert `read` with `address` = latched `instr_address` and `byteenable` = 4'hF; `writedata` = 0.
  - On completion, `instr_readdata <= readdata`, then go to RESP.
- RESP: lasts one cycle, with the strobes low. Then go to IDLE.
- `stall` is combinational:
  - 1 in IDLE when any request is pending.
  - 1 in DATA, FETCH and ERROR.
  - 0 in RESP, and 0 in IDLE with no request.
- While a strobe is high and `waitrequest` is high, `address`, `writedata`, `byteenable`, `read` and `write` hold stable.
- Outside DATA and FETCH: `read` = `write` = 0, `address` = 0, `byteenable` = 0, `writedata` = 0.
- The read-data registers hold their value until the next capture.

## Timing
- Reset asserted, at any time and immediately: all outputs are 0, state is IDLE, and the wait counter is 0. An in-flight transfer is abandoned with its strobe dropped, not completed.
- Fetch only, zero wait:
  - Cycle 0: IDLE, `stall` = 1.
  - Cycle 1: FETCH, `read` = 1.
  - Cycle 2: RESP, `stall` = 0, `instr_readdata` valid.
  - Cycle 3: IDLE.
- Each wait cycle adds one cycle to the phase it occurs in.
- Data plus fetch, zero wait: RESP is reached in cycle 3.
- The wait counter resets at each phase entry and increments on each `waitrequest`-high cycle while a strobe is high.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined:
  - When the wait counter reaches `WAIT_LIMIT` in DATA or FETCH, go to ERROR.
  - In ERROR, strobes are 0, `bus_error` = 1 and `stall` = 1, held until `reset`.
- Undefined:
  - No counter; the block waits on `waitrequest` indefinitely.
  - `bus_error` is tied to 0 and ERROR is unreachable.

## Test plan
- Fetch, zero wait: `instr_req`=1, `instr_address`=0xBFC00000, `readdata`=0x24020005 -> `read`=1 with `address`=0xBFC00000 and `byteenable`=F in cycle 1; cycle 2 `stall`=0 and `instr_readdata`=0x24020005.
- Load plus fetch, two wait cycles on the load: `data_read` at 0x00001000 returning 0x12345678 -> `address` holds 0x1000 for 3 cycles, then the fetch is issued; RESP in cycle 5 with `data_readdata`=0x12345678.
- Store: `data_write`, address 0x2000, data 0xDEADBEEF, byteenable 0011, plus fetch -> `write`=1 for one cycle with exact writedata/byteenable and `read`=0, then the fetch read; no change to `data_readdata`.
- `data_read` and `data_write` both high -> only `write` is asserted; no read phase occurs.
- Reset mid-DATA with `waitrequest` held high -> `read`/`write` drop to 0 in the same cycle; after release the block is in IDLE with `stall`=0 when there are no requests.
- With `MEM_BUS_TIMEOUT_EN` and `WAIT_LIMIT`=4, `waitrequest` stuck at 1 -> after 4 wait cycles `read`=0, `bus_error`=1 and `stall`=1, persisting until reset.

Source files
------------

// File: rtl/mem_bus_sequencer_if.sv
// Avalon-MM master bus between the sequencer and the memory fabric.
// No latency of its own; waitrequest is the slave's backpressure.
// Master holds address/strobes/data stable while waitrequest is high.
interface mem_bus_sequencer_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mem_bus_sequencer.sv
// Serialises CPU data access then instruction fetch onto one Avalon master.
// Latency: IDLE + 1 cycle per phase + RESP, each waitrequest cycle adds one.
// Backpressure: stall held high until both phases finish; MEM_BUS_TIMEOUT_EN adds a wait timeout.
module mem_bus_sequencer #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_req,
    input  logic [31:0]         instr_address,
    output logic [31:0]         instr_readdata,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [31:0]         data_address,
    input  logic [31:0]         data_writedata,
    input  logic [3:0]          data_byteenable,
    output logic [31:0]         data_readdata,
    output logic                stall,
    mem_bus_sequencer_if.master bus,
    output logic                bus_error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        FETCH = 3'd2,
        RESP  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t      state, next_state;

    logic        lat_instr_req;
    logic [31:0] lat_instr_address;
    logic        lat_write;
    logic [31:0] lat_data_address;
    logic [31:0] lat_writedata;
    logic [3:0]  lat_byteenable;

    logic        capture_data;
    logic        capture_instr;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;

    // The wait that would bring the counter to WAIT_LIMIT ends the phase.
    assign wait_expired = bus.waitrequest && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
`endif

    always_comb begin
        next_state     = state;
        capture_data   = 1'b0;
        capture_instr  = 1'b0;
        bus.address    = 32'h0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = 32'h0;
        bus.byteenable = 4'h0;

        case (state)
            IDLE: begin
                if (data_read || data_write) begin
                    next_state = DATA;
                end else if (instr_req) begin
                    next_state = FETCH;
                end
            end

            DATA: begin
                bus.address    = lat_data_address;
                bus.writedata  = lat_writedata;
                bus.byteenable = lat_byteenable;
                // A simultaneous load is dropped in favour of the store.
                bus.write      = lat_write;
                bus.read       = !lat_write;
                if (!bus.waitrequest) begin
                    capture_data = !lat_write;
                    next_state   = lat_instr_req ? FETCH : RESP;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (wait_expired) begin
                    next_state = ERROR;
                end
`endif
            end

            FETCH: begin
                bus.address    = lat_instr_address;
                bus.byteenable = 4'hF;
                bus.read       = 1'b1;
                if (!bus.waitrequest) begin
                    capture_instr = 1'b1;
                    next_state    = RESP;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (wait_expired) begin
                    next_state = ERROR;
                end
`endif
            end

            RESP: begin
                next_state = IDLE;
            end

            ERROR: begin
                next_state = ERROR;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = data_read || data_write || instr_req;
                RESP:    stall = 1'b0;
                default: stall = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request inputs are sampled on every IDLE edge; the CPU holds them while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_instr_req     <= 1'b0;
            lat_instr_address <= 32'h0;
            lat_write         <= 1'b0;
            lat_data_address  <= 32'h0;
            lat_writedata     <= 32'h0;
            lat_byteenable    <= 4'h0;
        end else if (state == IDLE) begin
            lat_instr_req     <= instr_req;
            lat_instr_address <= instr_address;
            lat_write         <= data_write;
            lat_data_address  <= data_address;
            lat_writedata     <= data_writedata;
            lat_byteenable    <= data_byteenable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_readdata  <= 32'h0;
            instr_readdata <= 32'h0;
        end else begin
            if (capture_data) begin
                data_readdata <= bus.readdata;
            end
            if (capture_instr) begin
                instr_readdata <= bus.readdata;
            end
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if ((state == DATA || state == FETCH) && bus.waitrequest) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign bus_error = (state == ERROR);
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Scoreboard bench: directed CPU requests, modelled Avalon slave, decoupled monitor.
module tb_mem_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req = 1'b0;
    logic [31:0] instr_address = 32'h0;
    logic [31:0] instr_readdata;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_address = 32'h0;
    logic [31:0] data_writedata = 32'h0;
    logic [3:0]  data_byteenable = 4'h0;
    logic [31:0] data_readdata;
    logic        stall;
    logic        bus_error;

    mem_bus_sequencer_if bus ();

    always #5 clk = ~clk;

    mem_bus_sequencer #(.WAIT_LIMIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_req       (instr_req),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .stall           (stall),
        .bus             (bus),
        .bus_error       (bus_error)
    );

    typedef struct {
        logic [31:0] a;
        logic        r;
        logic        w;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    typedef struct {
        logic [31:0] drd;
        logic [31:0] ird;
        int          issue;
        int          lat;
    } resp_t;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
    } slv_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    slv_t  slv_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] m_drd = 32'h0;
    logic [31:0] m_ird = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Avalon slave: each transfer pops a wait count and read data.
    bit          s_busy = 1'b0;
    int          s_rem = 0;
    logic [31:0] s_rdata = 32'h0;
    initial begin
        bus.waitrequest = 1'b0;
        bus.readdata = 32'h0;
    end
    always @(negedge clk) begin
        if (reset) begin
            s_busy = 1'b0;
            s_rem = 0;
            bus.waitrequest = 1'b0;
        end else if (bus.read || bus.write) begin
            if (!s_busy) begin
                if (slv_q.size() > 0) begin
                    slv_t s;
                    s = slv_q.pop_front();
                    s_rem = s.waits;
                    s_rdata = s.rdata;
                end else begin
                    s_rem = 0;
                    s_rdata = 32'h0;
                end
                s_busy = 1'b1;
            end
            bus.waitrequest = (s_rem > 0);
            bus.readdata = s_rdata;
            if (s_rem > 0) s_rem--;
            else s_busy = 1'b0;
        end else begin
            s_busy = 1'b0;
            bus.waitrequest = 1'b0;
        end
    end

    // Monitor: compares completed transfers and responses against the queues.
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        #1;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if ((bus.read || bus.write) && !bus.waitrequest) begin
                if (bus_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transfer: got addr %h rd %b wr %b want none", bus.address, bus.read, bus.write);
                end else begin
                    bus_t e;
                    e = bus_q.pop_front();
                    check("xfer_address", bus.address, e.a);
                    check("xfer_read", {31'h0, bus.read}, {31'h0, e.r});
                    check("xfer_write", {31'h0, bus.write}, {31'h0, e.w});
                    check("xfer_byteenable", {28'h0, bus.byteenable}, {28'h0, e.be});
                    check("xfer_writedata", bus.writedata, e.wd);
                end
            end
            if (prev_stall && !stall) begin
                if (resp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got stall release want none");
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("resp_data_readdata", data_readdata, r.drd);
                    check("resp_instr_readdata", instr_readdata, r.ird);
                    check("resp_latency", cyc - r.issue, r.lat);
                end
            end
            prev_stall = stall;
        end
    end

    task automatic do_op(input logic rd, input logic wr, input logic ireq,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int dw, input logic [31:0] drdata,
                         input int fw, input logic [31:0] irdata,
                         input int lat);
        resp_t r;
        int    data_cycles;
        bit    done;
        @(negedge clk);
        if (rd || wr) begin
            slv_q.push_back('{dw, drdata});
            bus_q.push_back('{da, !wr, wr, be, wd});
            if (!wr) m_drd = drdata;
        end
        if (ireq) begin
            slv_q.push_back('{fw, irdata});
            bus_q.push_back('{ia, 1'b1, 1'b0, 4'hF, 32'h0});
            m_ird = irdata;
        end
        r.drd = m_drd;
        r.ird = m_ird;
        r.issue = cyc;
        r.lat = lat;
        resp_q.push_back(r);
        data_read = rd;
        data_write = wr;
        instr_req = ireq;
        instr_address = ia;
        data_address = da;
        data_writedata = wd;
        data_byteenable = be;
        #1;
        check("idle_stall", {31'h0, stall}, 32'h1);
        data_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #2;
            if ((bus.read || bus.write) && bus.address == da) data_cycles++;
            if (!stall) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL op_timeout: got stall held 100 cycles want release");
        end
        if (rd || wr) check("data_phase_cycles", data_cycles, dw + 1);
        data_read = 1'b0;
        data_write = 1'b0;
        instr_req = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_read", {31'h0, bus.read}, 32'h0);
        check("rst_write", {31'h0, bus.write}, 32'h0);
        check("rst_address", bus.address, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_data_readdata", data_readdata, 32'h0);
        check("rst_instr_readdata", instr_readdata, 32'h0);
        check("rst_bus_error", {31'h0, bus_error}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        //     rd    wr    ireq  iaddr         daddr         wdata         be    dw  drdata        fw irdata        lat
        do_op(1'b0, 1'b0, 1'b1, 32'hBFC00000, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h24020005, 2);
        do_op(1'b1, 1'b0, 1'b1, 32'hBFC00004, 32'h00001000, 32'h0,        4'hF, 2, 32'h12345678, 0, 32'h8C010000, 5);
        do_op(1'b0, 1'b1, 1'b1, 32'hBFC00008, 32'h00002000, 32'hDEADBEEF, 4'h3, 0, 32'h0,        0, 32'hAC020004, 3);
        do_op(1'b1, 1'b1, 1'b0, 32'h0,        32'h00002004, 32'hCAFEF00D, 4'hF, 0, 32'h0,        0, 32'h0,        2);
        do_op(1'b1, 1'b0, 1'b0, 32'h0,        32'h00001004, 32'h0,        4'hF, 0, 32'h0BADF00D, 0, 32'h0,        2);
        do_op(1'b0, 1'b0, 1'b1, 32'hBFC0000C, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 32'h03E00008, 3);

        // Reset while a load is stuck in waitrequest.
        @(negedge clk);
        slv_q.push_back('{50, 32'h55555555});
        data_read = 1'b1;
        data_address = 32'h00003000;
        data_byteenable = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("stuck_read_high", {31'h0, bus.read}, 32'h1);
        check("stuck_waitrequest", {31'h0, bus.waitrequest}, 32'h1);
        reset = 1'b1;
        #1;
        check("midrst_read", {31'h0, bus.read}, 32'h0);
        check("midrst_write", {31'h0, bus.write}, 32'h0);
        check("midrst_address", bus.address, 32'h0);
        check("midrst_stall", {31'h0, stall}, 32'h0);
        check("midrst_data_readdata", data_readdata, 32'h0);
        check("midrst_instr_readdata", instr_readdata, 32'h0);
        m_drd = 32'h0;
        m_ird = 32'h0;
        data_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("postrst_stall", {31'h0, stall}, 32'h0);
        check("postrst_read", {31'h0, bus.read}, 32'h0);
        do_op(1'b0, 1'b0, 1'b1, 32'hBFC00010, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h00000000 | 32'h27BDFFF0, 2);

`ifdef MEM_BUS_TIMEOUT_EN
        @(negedge clk);
        slv_q.push_back('{1000, 32'h0});
        data_read = 1'b1;
        data_address = 32'h00004000;
        data_byteenable = 4'hF;
        repeat (5) @(negedge clk);
        #2;
        check("to_read", {31'h0, bus.read}, 32'h0);
        check("to_bus_error", {31'h0, bus_error}, 32'h1);
        check("to_stall", {31'h0, stall}, 32'h1);
        repeat (3) @(negedge clk);
        #2;
        check("to_bus_error_hold", {31'h0, bus_error}, 32'h1);
        check("to_stall_hold", {31'h0, stall}, 32'h1);
        data_read = 1'b0;
        reset = 1'b1;
        #1;
        check("to_rst_bus_error", {31'h0, bus_error}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        slv_q.delete();
`endif

        repeat (3) @(negedge clk);
        check("bus_q_empty", bus_q.size(), 0);
        check("resp_q_empty", resp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
